// File: rtl/store_narrow_unit.sv
// store_narrow_unit
//
// Sub-word store unit for the unpipelined MIPS core. It narrows a register
// value to a byte, halfword or word and commits it to a word-only data
// memory. Byte and halfword stores read the target word first, splice in the
// new lane and write the merged word back. Aligned word stores go straight to
// the write phase.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_req          store request, accepted when i_req && o_ready
//   o_ready        high only while idle
//   i_addr         byte address
//   i_data         register source data
//   i_size         00 byte, 01 halfword, 10 word, 11 reserved
//   o_mem_addr     word address (byte address with the low two bits dropped)
//   o_mem_rd       read strobe, held until i_mem_rvalid
//   i_mem_rvalid   read data valid
//   i_mem_rdata    read data
//   o_mem_wr       write strobe, held until i_mem_wack
//   o_mem_wdata    merged write word
//   i_mem_wack     write accepted
//   o_done         one-cycle pulse, store committed
//   o_misalign     one-cycle pulse, request rejected

module store_narrow_unit #(
    parameter int AW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req,
    output logic          o_ready,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_data,
    input  logic [1:0]    i_size,
    output logic [AW-3:0] o_mem_addr,
    output logic          o_mem_rd,
    input  logic          i_mem_rvalid,
    input  logic [31:0]   i_mem_rdata,
    output logic          o_mem_wr,
    output logic [31:0]   o_mem_wdata,
    input  logic          i_mem_wack,
    output logic          o_done,
    output logic          o_misalign
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t      state;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [15:0] narrow_q;

    logic        req_misaligned;
    logic [15:0] req_narrow;
    logic [31:0] merged_word;

    // Classify the incoming request. Reserved sizes and unaligned halfword or
    // word addresses are rejected without touching memory.
    always_comb begin
        req_misaligned = 1'b0;
        case (i_size)
            SIZE_BYTE: req_misaligned = 1'b0;
            SIZE_HALF: req_misaligned = i_addr[0];
            SIZE_WORD: req_misaligned = (i_addr[1:0] != 2'b00);
            default:   req_misaligned = 1'b1;
        endcase
    end

    // Only the low 16 bits are ever needed after accept: the word path writes
    // i_data straight into o_mem_wdata, so it never reads narrow_q.
    always_comb begin
        req_narrow = i_data[15:0];
        if (i_size == SIZE_BYTE) begin
            req_narrow = {8'h00, i_data[7:0]};
        end
    end

    // Splice the stored lane into the word read back from memory. Lanes are
    // little-endian: byte lane k owns bits [8k+7:8k], halfword lane 2 owns the
    // upper half. Everything outside the lane is preserved from memory.
    always_comb begin
        merged_word = i_mem_rdata;
        if (size_q == SIZE_BYTE) begin
            case (lane_q)
                2'd0:    merged_word[7:0]   = narrow_q[7:0];
                2'd1:    merged_word[15:8]  = narrow_q[7:0];
                2'd2:    merged_word[23:16] = narrow_q[7:0];
                default: merged_word[31:24] = narrow_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged_word[31:16] = narrow_q;
        end else begin
            merged_word[15:0] = narrow_q;
        end
    end

    // Control FSM. Every output is a flop updated alongside the state, so no
    // input reaches an output combinationally. A reset in the middle of a
    // read-modify-write simply abandons it; nothing is written afterwards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_ready     <= 1'b1;
            o_mem_rd    <= 1'b0;
            o_mem_wr    <= 1'b0;
            o_done      <= 1'b0;
            o_misalign  <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            size_q      <= '0;
            lane_q      <= '0;
            narrow_q    <= '0;
        end else begin
            o_done     <= 1'b0;
            o_misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req) begin
                        o_ready    <= 1'b0;
                        o_mem_addr <= i_addr[AW-1:2];
                        size_q     <= i_size;
                        lane_q     <= i_addr[1:0];
                        narrow_q   <= req_narrow;
                        if (req_misaligned) begin
                            state      <= ERR;
                            o_misalign <= 1'b1;
                        end else if (i_size == SIZE_WORD) begin
                            state       <= WR;
                            o_mem_wr    <= 1'b1;
                            o_mem_wdata <= i_data;
                        end else begin
                            state    <= RD;
                            o_mem_rd <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (i_mem_rvalid) begin
                        state       <= WR;
                        o_mem_rd    <= 1'b0;
                        o_mem_wr    <= 1'b1;
                        o_mem_wdata <= merged_word;
                    end
                end
                WR: begin
                    if (i_mem_wack) begin
                        state    <= DONE;
                        o_mem_wr <= 1'b0;
                        o_done   <= 1'b1;
                    end
                end
                DONE, ERR: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    o_ready  <= 1'b1;
                    o_mem_rd <= 1'b0;
                    o_mem_wr <= 1'b0;
                end
            endcase
        end
    end

endmodule
